alu_sched: RTL and testbench

//  Shares the single 16-bit ALU between two requesters: port 0 (execute stage) and port 1 (debug/BIST).

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_sched_alu.sv | 69 ++++++
 rtl/alu_sched.sv | 108 ++++++++++
 tb/tb_alu_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode/state types, datapath width and the per-opcode flag write-enable.
// Imported by the scheduler and its ALU.
package alu_pkg;

    localparam int ALU_DW = 16;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_XOR    = 3'd2,
        OP_RED    = 3'd3,
        OP_SLL    = 3'd4,
        OP_SRA    = 3'd5,
        OP_ROR    = 3'd6,
        OP_PADDSB = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_t;

    localparam int N_IDX = 2;
    localparam int V_IDX = 1;
    localparam int Z_IDX = 0;

    // Which bits of the architectural {N,V,Z} register an opcode may write.
    function automatic logic [2:0] flag_mask(input alu_op_t op);
        logic [2:0] m;
        m = 3'b000;
        case (op)
            OP_ADD, OP_SUB: begin
                m[N_IDX] = 1'b1;
                m[V_IDX] = 1'b1;
                m[Z_IDX] = 1'b1;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[Z_IDX] = 1'b1;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_sched_alu.sv
// 16-bit ALU: saturating add/sub, logic, parity reduction, shifts/rotate, packed saturating byte add.
// Latency: purely combinational.
// Backpressure: none; result follows the operands.
module alu_sched_alu
    import alu_pkg::*;
(
    input  logic [ALU_DW-1:0] a,
    input  logic [ALU_DW-1:0] b,
    input  alu_op_t           op,
    output logic [ALU_DW-1:0] result,
    output logic [2:0]        nvz
);

    localparam logic [ALU_DW-1:0] POS_MAX = {1'b0, {(ALU_DW-1){1'b1}}};
    localparam logic [ALU_DW-1:0] NEG_MAX = {1'b1, {(ALU_DW-1){1'b0}}};

    logic [ALU_DW:0] sum_ext;
    logic [ALU_DW:0] dif_ext;
    logic [3:0]      sh;
    logic [8:0]      bsum_lo;
    logic [8:0]      bsum_hi;
    logic            ovf_lo;
    logic            ovf_hi;
    logic [7:0]      sat_lo;
    logic [7:0]      sat_hi;
    logic            ovf;

    assign sh = b[3:0];

    // One extra sign bit makes overflow detectable and gives the true sign for saturation.
    assign sum_ext = {a[ALU_DW-1], a} + {b[ALU_DW-1], b};
    assign dif_ext = {a[ALU_DW-1], a} - {b[ALU_DW-1], b};
    assign bsum_lo = {a[7], a[7:0]} + {b[7], b[7:0]};
    assign bsum_hi = {a[15], a[15:8]} + {b[15], b[15:8]};
    assign ovf_lo  = bsum_lo[8] ^ bsum_lo[7];
    assign ovf_hi  = bsum_hi[8] ^ bsum_hi[7];
    assign sat_lo  = ovf_lo ? (bsum_lo[8] ? 8'h80 : 8'h7F) : bsum_lo[7:0];
    assign sat_hi  = ovf_hi ? (bsum_hi[8] ? 8'h80 : 8'h7F) : bsum_hi[7:0];

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                ovf    = sum_ext[ALU_DW] ^ sum_ext[ALU_DW-1];
                result = ovf ? (sum_ext[ALU_DW] ? NEG_MAX : POS_MAX) : sum_ext[ALU_DW-1:0];
            end
            OP_SUB: begin
                ovf    = dif_ext[ALU_DW] ^ dif_ext[ALU_DW-1];
                result = ovf ? (dif_ext[ALU_DW] ? NEG_MAX : POS_MAX) : dif_ext[ALU_DW-1:0];
            end
            OP_XOR:    result = a ^ b;
            OP_RED:    result = {{(ALU_DW-1){1'b0}}, ^a};
            OP_SLL:    result = a << sh;
            OP_SRA:    result = $signed(a) >>> sh;
            OP_ROR:    result = (a >> sh) | (a << (5'd16 - {1'b0, sh}));
            OP_PADDSB: begin
                ovf    = ovf_lo | ovf_hi;
                result = {sat_hi, sat_lo};
            end
            default: result = '0;
        endcase
    end

    assign nvz[N_IDX] = result[ALU_DW-1];
    assign nvz[V_IDX] = ovf;
    assign nvz[Z_IDX] = (result == '0);

endmodule

// File: rtl/alu_sched.sv
// Arbitrates two requesters onto one ALU, sequences one op at a time, owns the {N,V,Z} flag register.
// Latency: response valid two cycles after the request handshake; at most one op in flight.
// Backpressure: request ready only in IDLE to the arbitration winner; response held until rsp_ready.
module alu_sched
    import alu_pkg::*;
#(
    parameter int DW         = 16,
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [2:0]    req0_op,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [2:0]    req1_op,
    input  logic          flush,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic [2:0]    rsp_nvz,
    output logic [2:0]    flags_nvz
);

    sched_state_t  state_q, state_d;
    logic          rr_q;
    logic [DW-1:0] a_q, b_q;
    alu_op_t       op_q;
    logic          id_q;
    logic [DW-1:0] data_q;
    logic [2:0]    nvz_q;
    logic [2:0]    flags_q;
    logic [DW-1:0] alu_result;
    logic [2:0]    alu_nvz;
    logic [2:0]    mask;
    logic          cand0, cand1, grant0, grant1, accept, kill;

    // A flush blocks port 0 from arbitration; rr_q=1 means port 1 is favoured on contention.
    assign cand0  = req0_valid & ~flush;
    assign cand1  = req1_valid;
    assign grant0 = cand0 & (~cand1 | PRIO_FIXED | ~rr_q);
    assign grant1 = cand1 & ~grant0;

    assign req0_ready = rst_n & (state_q == ST_IDLE) & grant0;
    assign req1_ready = rst_n & (state_q == ST_IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;
    assign kill       = flush & ~id_q;
    assign mask       = flag_mask(op_q);

    alu_sched_alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .nvz    (alu_nvz)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = kill ? ST_IDLE : ST_RESP;
            ST_RESP: if (rsp_ready | kill) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            id_q    <= 1'b0;
            data_q  <= '0;
            nvz_q   <= 3'b000;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && accept) begin
                a_q  <= grant0 ? req0_a : req1_a;
                b_q  <= grant0 ? req0_b : req1_b;
                op_q <= alu_op_t'(grant0 ? req0_op : req1_op);
                id_q <= grant1;
                if (cand0 & cand1) rr_q <= grant0;
            end
            if (state_q == ST_EXEC && !kill) begin
                data_q <= alu_result;
                nvz_q  <= alu_nvz;
                if (!id_q) flags_q <= (flags_q & ~mask) | (alu_nvz & mask);
            end
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_nvz   = nvz_q;
    assign flags_nvz = flags_q;

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: directed boundary cases plus a randomized phase against a reference model.
module tb_alu_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, flush, rsp_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_nvz, flags_nvz;
    logic        fx_req0_ready, fx_req1_ready, fx_rsp_valid, fx_rsp_id;
    logic [15:0] fx_rsp_data;
    logic [2:0]  fx_rsp_nvz, fx_flags_nvz;

    always #5 clk = ~clk;

    alu_sched #(.DW(16), .PRIO_FIXED(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_nvz(rsp_nvz), .flags_nvz(flags_nvz)
    );

    alu_sched #(.DW(16), .PRIO_FIXED(1'b1)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fx_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(fx_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .flush(flush), .rsp_valid(fx_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fx_rsp_id),
        .rsp_data(fx_rsp_data), .rsp_nvz(fx_rsp_nvz), .flags_nvz(fx_flags_nvz)
    );

    typedef struct {
        logic        id;
        logic [15:0] data;
        logic [2:0]  nvz;
        logic [2:0]  flags;
        int          acc_cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         grants[$];
    logic [2:0] model_flags = 3'b000;
    int         checks = 0;
    int         fails = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference ALU computed with signed integer arithmetic and explicit clamping.
    function automatic void ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic [2:0] nvz);
        int   s, n, ua;
        logic v;
        n  = int'(b[3:0]);
        ua = int'(a);
        v  = 1'b0;
        r  = 16'h0000;
        case (op)
            3'd0, 3'd1: begin
                s = (op == 3'd0) ? int'($signed(a)) + int'($signed(b)) : int'($signed(a)) - int'($signed(b));
                if (s > 32767) begin s = 32767; v = 1'b1; end
                else if (s < -32768) begin s = -32768; v = 1'b1; end
                r = s[15:0];
            end
            3'd2: r = a ^ b;
            3'd3: r = 16'($countones(a) % 2);
            3'd4: begin s = ua << n; r = s[15:0]; end
            3'd5: begin s = int'($signed(a)) >>> n; r = s[15:0]; end
            3'd6: begin s = (ua >> n) | (ua << (16 - n)); r = s[15:0]; end
            default: begin
                for (int k = 0; k < 2; k++) begin
                    s = int'($signed(a[8*k +: 8])) + int'($signed(b[8*k +: 8]));
                    if (s > 127) begin s = 127; v = 1'b1; end
                    else if (s < -128) begin s = -128; v = 1'b1; end
                    r[8*k +: 8] = s[7:0];
                end
            end
        endcase
        nvz = {r[15], v, (r == 16'h0000)};
    endfunction

    function automatic logic [2:0] next_flags(input logic [2:0] f, input logic [2:0] op, input logic [2:0] nvz);
        case (op)
            3'd0, 3'd1:             return nvz;
            3'd2, 3'd4, 3'd5, 3'd6: return {f[2:1], nvz[0]};
            default:                return f;
        endcase
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 6))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            4:       return 16'h007F;
            5:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic push(input logic id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        ref_alu(op, a, b, e.data, e.nvz);
        if (!id) model_flags = next_flags(model_flags, op, e.nvz);
        e.id      = id;
        e.flags   = model_flags;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        grants.push_back(int'(id));
    endtask

    // Accept watcher: each request handshake enqueues its expected response.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("one_grant", {31'b0, req0_ready & req1_ready}, 0);
            if (req0_valid && req0_ready) push(1'b0, req0_op, req0_a, req0_b);
            if (req1_valid && req1_ready) push(1'b1, req1_op, req1_a, req1_b);
        end
    end

    // Response monitor: latency on the rising response, contents on the handshake.
    initial begin
        exp_t e;
        logic prev_vld;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", {31'b0, rsp_valid}, 0);
                end else begin
                    e = exp_q[0];
                    if (!prev_vld) check("latency", cyc - e.acc_cyc, 2);
                    if (rsp_ready) begin
                        e = exp_q.pop_front();
                        check("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
                        check("rsp_data", {16'b0, rsp_data}, {16'b0, e.data});
                        check("rsp_nvz", {29'b0, rsp_nvz}, {29'b0, e.nvz});
                        check("flags_nvz", {29'b0, flags_nvz}, {29'b0, e.flags});
                    end
                end
            end
            prev_vld = rst_n && rsp_valid;
        end
    end

    task automatic issue(input bit port, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int waits);
        bit got;
        got   = 1'b0;
        waits = 0;
        if (!port) begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
        else       begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
        while (!got && waits < 20) begin
            @(negedge clk);
            waits++;
            got = port ? req1_ready : req0_ready;
        end
        if (!got) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!port) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w, fx_g0;
        logic [2:0] saved;
        logic [21:0] snap;
        exp_t       dummy;
        bit         got0, got1;

        rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
        #12;
        check("rst_req0_ready", {31'b0, req0_ready}, 0);
        check("rst_req1_ready", {31'b0, req1_ready}, 0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rst_rsp_id", {31'b0, rsp_id}, 0);
        check("rst_rsp_data", {16'b0, rsp_data}, 0);
        check("rst_rsp_nvz", {29'b0, rsp_nvz}, 0);
        check("rst_flags", {29'b0, flags_nvz}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Saturating add sets V, then logic/reduction ops touch only Z or nothing.
        issue(0, 3'd0, 16'h7FFF, 16'h0001, w); drain("t1");
        check("t1_flags", {29'b0, flags_nvz}, 3'b010);
        issue(0, 3'd2, 16'hFFFF, 16'hFFFF, w); drain("t2a");
        check("t2_xor_keeps_nv", {29'b0, flags_nvz}, 3'b011);
        issue(0, 3'd1, 16'h0005, 16'h0005, w); drain("t2b");
        issue(0, 3'd2, 16'hFFFF, 16'hFFFF, w); drain("t2c");
        issue(0, 3'd3, 16'h0001, 16'h0000, w); drain("t2d");
        check("t2_red_flags", {29'b0, flags_nvz}, 3'b001);
        issue(1, 3'd1, 16'h0000, 16'h0001, w); drain("t4");
        check("t4_port1_flags", {29'b0, flags_nvz}, 3'b001);

        // Contention: round-robin on the main instance, fixed priority on the second one.
        grants.delete();
        fx_g0 = 0;
        req0_op = 3'd0; req0_a = 16'h0001; req0_b = 16'h0002;
        req1_op = 3'd1; req1_a = 16'h0003; req1_b = 16'h0001;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("fx_port1_blocked", {31'b0, fx_req1_ready}, 0);
            fx_g0 += int'(fx_req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain("t3");
        check("t3_grant_count", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++) check("t3_rr_grant", grants[i], i % 2);
        check("fx_port0_granted", {31'b0, fx_g0 > 0}, 1);

        // Flush during EXEC kills the op and the next request is accepted straight away.
        saved = model_flags;
        issue(0, 3'd0, 16'h0001, 16'h0001, w);
        flush = 1'b1;
        @(negedge clk);
        check("t5_exec_no_rsp", {31'b0, rsp_valid}, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        dummy = exp_q.pop_back();
        model_flags = saved;
        check("t5_flags_kept", {29'b0, flags_nvz}, {29'b0, saved});
        issue(0, 3'd0, 16'h8000, 16'hFFFF, w);
        check("t5_next_accept", w, 1);
        drain("t5a");

        flush = 1'b1; req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h0001; req0_b = 16'h0002;
        @(negedge clk);
        check("t5_idle_block", {31'b0, req0_ready}, 0);
        @(posedge clk); #1;
        flush = 1'b0; req0_valid = 1'b0;

        rsp_ready = 1'b0;
        issue(0, 3'd2, 16'h0000, 16'h0000, w);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("t5_resp_vld", {31'b0, rsp_valid}, 1);
        @(posedge clk); #1;
        flush = 1'b0; rsp_ready = 1'b1;
        dummy = exp_q.pop_back();
        @(negedge clk);
        check("t5_resp_drop", {31'b0, rsp_valid}, 0);
        check("t5_resp_flags", {29'b0, flags_nvz}, {29'b0, model_flags});
        @(posedge clk); #1;

        issue(1, 3'd6, 16'h0001, 16'h0001, w);
        flush = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b0;
        drain("t5_port1");

        // Held response stays stable and blocks requests; reset mid-hold clears everything.
        rsp_ready = 1'b0;
        issue(0, 3'd1, 16'h8000, 16'h0001, w);
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        snap = {rsp_id, rsp_data, rsp_nvz, flags_nvz};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_stable", {10'b0, rsp_id, rsp_data, rsp_nvz, flags_nvz}, {10'b0, snap});
            check("t6_hold_vld", {31'b0, rsp_valid}, 1);
            check("t6_req0_blocked", {31'b0, req0_ready}, 0);
            check("t6_req1_blocked", {31'b0, req1_ready}, 0);
        end
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {24'b0, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_nvz, 1'b0}, 0);
        check("t6_rst_data", {16'b0, rsp_data}, 0);
        check("t6_rst_flags", {29'b0, flags_nvz}, 0);
        exp_q.delete();
        model_flags = 3'b000;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_rsp_after_rst", {31'b0, rsp_valid}, 0);
        end
        check("t6_flags_cleared", {29'b0, flags_nvz}, 0);
        @(posedge clk); #1;

        // Randomized traffic with random response backpressure.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            got0 = req0_valid && req0_ready;
            got1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (!req0_valid || got0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_op = 3'($urandom_range(0, 7)); req0_a = pick(); req0_b = pick();
            end
            if (!req1_valid || got1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_op = 3'($urandom_range(0, 7)); req1_a = pick(); req1_b = pick();
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        got0 = req0_valid && req0_ready;
        got1 = req1_valid && req1_ready;
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        drain("random");
        check("final_flags", {29'b0, flags_nvz}, {29'b0, model_flags});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
